// File: rtl/lcd1602_disp_sched_pkg.sv
// Shared types and constants for the LCD1602 command scheduler.
// The frame is 32 chars: char 0 sits in the most significant byte of the frame vector.
package lcd1602_disp_sched_pkg;

  localparam int unsigned NCHAR   = 32;
  localparam int unsigned ROW_LEN = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFClr,
    StFCur,
    StFDat,
    StCCur,
    StCDat,
    StWait
  } state_e;

  function automatic logic [7:0] frame_char(input logic [8*NCHAR-1:0] frame,
                                            input logic [4:0]         idx);
    return frame[8*NCHAR-1-8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/lcd1602_disp_sched_if.sv
// Producer/controller signal bundle for the LCD1602 command scheduler.
// The master side drives requests and controller status; the slave side is the scheduler.
interface lcd1602_disp_sched_if;

  logic                                       Init_Done;
  logic                                       Cmd_Done;
  logic                                       Frame_Req;
  logic [8*lcd1602_disp_sched_pkg::NCHAR-1:0] Frame_Data;
  logic                                       Chr_Req;
  logic [4:0]                                 Chr_Pos;
  logic [7:0]                                 Chr_Data;
  logic                                       Chr_Ack;
  logic                                       Frame_Busy;
  logic                                       Frame_Done;
  logic                                       Timeout_Err;
  logic [7:0]                                 Pos;
  logic                                       Set_Cursor;
  logic [7:0]                                 Data;
  logic                                       Set_Data;
  logic                                       Clr_Screen;

  modport master (
    output Init_Done, Cmd_Done, Frame_Req, Frame_Data, Chr_Req, Chr_Pos, Chr_Data,
    input  Chr_Ack, Frame_Busy, Frame_Done, Timeout_Err, Pos, Set_Cursor, Data, Set_Data,
           Clr_Screen
  );

  modport slave (
    input  Init_Done, Cmd_Done, Frame_Req, Frame_Data, Chr_Req, Chr_Pos, Chr_Data,
    output Chr_Ack, Frame_Busy, Frame_Done, Timeout_Err, Pos, Set_Cursor, Data, Set_Data,
           Clr_Screen
  );

endinterface

// File: rtl/lcd1602_disp_sched_wdog.sv
// Command-completion watchdog: counts while run_i is high, clears whenever it is low.
// expire_o is high in the TMO_MAX-th consecutive run cycle.
module lcd1602_disp_sched_wdog #(
  parameter int unsigned TMO_W   = 20,
  parameter int unsigned TMO_MAX = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic expire_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && (cnt_q == TMO_W'(TMO_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd1602_disp_sched.sv
// LCD1602 command scheduler: serialises a 32-char frame refresh and single-char writes
// into one-at-a-time controller commands, interleaving chars at frame char boundaries.
module lcd1602_disp_sched
  import lcd1602_disp_sched_pkg::*;
#(
  parameter int unsigned TMO_W   = 20,
  parameter int unsigned TMO_MAX = 1000000
) (
  input logic                 Clk,
  input logic                 Rst,
  lcd1602_disp_sched_if.slave bus
);

  state_e               state_q, state_d, ret_q, ret_d;
  logic [5:0]           idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic                 need_cur_q, need_cur_d;
  logic                 busy_q, busy_d;
  logic                 at_bnd_q, at_bnd_d;
  logic                 served_q, served_d;
  logic [4:0]           cpos_q, cpos_d;
  logic [7:0]           cdata_q, cdata_d;
  logic [8*NCHAR-1:0]   frame_q, frame_d;
  logic [7:0]           pos_q, pos_d, data_q, data_d;
  logic                 set_cur_q, set_cur_d, set_dat_q, set_dat_d, clr_q, clr_d;
  logic                 ack_q, ack_d, done_q, done_d, tmo_q, tmo_d;
  logic                 wd_expire;

  lcd1602_disp_sched_wdog #(
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) u_wdog (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .run_i   (state_q == StWait),
    .expire_o(wd_expire)
  );

  assign bus.Pos         = pos_q;
  assign bus.Data        = data_q;
  assign bus.Set_Cursor  = set_cur_q;
  assign bus.Set_Data    = set_dat_q;
  assign bus.Clr_Screen  = clr_q;
  assign bus.Chr_Ack     = ack_q;
  assign bus.Frame_Busy  = busy_q;
  assign bus.Frame_Done  = done_q;
  assign bus.Timeout_Err = tmo_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    idx_d      = idx_q;
    pend_d     = pend_q | bus.Frame_Req;
    need_cur_d = need_cur_q;
    busy_d     = busy_q;
    at_bnd_d   = at_bnd_q;
    served_d   = served_q;
    cpos_d     = cpos_q;
    cdata_d    = cdata_q;
    frame_d    = frame_q;
    pos_d      = pos_q;
    data_d     = data_q;
    set_cur_d  = 1'b0;
    set_dat_d  = 1'b0;
    clr_d      = 1'b0;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;

    // Abort path shared by the watchdog and a dropped Init_Done; a pending frame survives.
    if (state_q != StIdle && (!bus.Init_Done || wd_expire)) begin
      tmo_d      = bus.Init_Done;
      state_d    = StIdle;
      busy_d     = 1'b0;
      need_cur_d = 1'b1;
      at_bnd_d   = 1'b0;
      served_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.Init_Done) begin
            if (bus.Chr_Req) begin
              ack_d      = 1'b1;
              cpos_d     = bus.Chr_Pos;
              cdata_d    = bus.Chr_Data;
              need_cur_d = 1'b1;
              state_d    = StCCur;
            end else if (bus.Frame_Req || pend_q) begin
              frame_d  = bus.Frame_Data;
              idx_d    = '0;
              busy_d   = 1'b1;
              pend_d   = 1'b0;
              at_bnd_d = 1'b0;
              served_d = 1'b0;
              state_d  = StFClr;
            end
          end
        end
        StFClr: begin
          clr_d   = 1'b1;
          ret_d   = StFCur;
          state_d = StWait;
        end
        StFCur: begin
          if (at_bnd_q && idx_q == 6'(NCHAR)) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            at_bnd_d = 1'b0;
            state_d  = StIdle;
          end else if (at_bnd_q && bus.Chr_Req && !served_q) begin
            // Serving only every other boundary keeps the frame moving under a held Chr_Req.
            ack_d      = 1'b1;
            cpos_d     = bus.Chr_Pos;
            cdata_d    = bus.Chr_Data;
            need_cur_d = 1'b1;
            served_d   = 1'b1;
            at_bnd_d   = 1'b0;
            state_d    = StCCur;
          end else begin
            at_bnd_d = 1'b0;
            if (at_bnd_q) served_d = 1'b0;
            if (need_cur_q || (idx_q % 6'(ROW_LEN)) == 6'd0) begin
              pos_d      = {3'b000, idx_q[4:0]};
              set_cur_d  = 1'b1;
              need_cur_d = 1'b0;
              ret_d      = StFDat;
              state_d    = StWait;
            end else begin
              state_d = StFDat;
            end
          end
        end
        StFDat: begin
          data_d    = frame_char(frame_q, idx_q[4:0]);
          set_dat_d = 1'b1;
          idx_d     = idx_q + 6'd1;
          at_bnd_d  = 1'b1;
          ret_d     = StFCur;
          state_d   = StWait;
        end
        StCCur: begin
          pos_d     = {3'b000, cpos_q};
          set_cur_d = 1'b1;
          ret_d     = StCDat;
          state_d   = StWait;
        end
        StCDat: begin
          data_d    = cdata_q;
          set_dat_d = 1'b1;
          ret_d     = busy_q ? StFCur : StIdle;
          state_d   = StWait;
        end
        StWait: begin
          if (bus.Cmd_Done) state_d = ret_q;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      need_cur_q <= 1'b1;
      busy_q     <= 1'b0;
      at_bnd_q   <= 1'b0;
      served_q   <= 1'b0;
      cpos_q     <= '0;
      cdata_q    <= '0;
      frame_q    <= '0;
      pos_q      <= '0;
      data_q     <= '0;
      set_cur_q  <= 1'b0;
      set_dat_q  <= 1'b0;
      clr_q      <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      need_cur_q <= need_cur_d;
      busy_q     <= busy_d;
      at_bnd_q   <= at_bnd_d;
      served_q   <= served_d;
      cpos_q     <= cpos_d;
      cdata_q    <= cdata_d;
      frame_q    <= frame_d;
      pos_q      <= pos_d;
      data_q     <= data_d;
      set_cur_q  <= set_cur_d;
      set_dat_q  <= set_dat_d;
      clr_q      <= clr_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_lcd1602_disp_sched.sv
// Scoreboard bench for lcd1602_disp_sched: stimulus pushes expected events, a negedge
// monitor pops them as strobes/pulses appear and also plays the controller (Cmd_Done).
module tb_lcd1602_disp_sched;

  localparam int unsigned TMO = 50;
  localparam logic [7:0] K_CLR  = 8'd1;
  localparam logic [7:0] K_CUR  = 8'd2;
  localparam logic [7:0] K_DAT  = 8'd3;
  localparam logic [7:0] K_DONE = 8'd4;
  localparam logic [7:0] K_ACK  = 8'd5;
  localparam logic [7:0] K_TMO  = 8'd6;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  lcd1602_disp_sched_if bus();

  lcd1602_disp_sched #(
    .TMO_W  (20),
    .TMO_MAX(TMO)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  logic [15:0] exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ev_cnt = 0;
  int    dat_cnt = 0;
  int    hold_at = -1;
  int    cd = 0;
  int    cyc = 0;
  int    dat_cyc = 0;
  int    tmo_cyc = 0;
  logic  busy_seen = 1'b0;
  string fs = "HELLO WORLD     0123456789ABCDEF";

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic got(input logic [15:0] ev);
    logic [15:0] e;
    checks++;
    ev_cnt++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected %04h, required none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL event: got %04h, required %04h", ev, e);
      end
    end
  endtask

  task automatic push(input logic [7:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic push_chars(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i % 16 == 0) push(K_CUR, 8'(i));
      push(K_DAT, fs[i]);
    end
  endtask

  task automatic push_frame();
    push(K_CLR, 8'h00);
    push_chars(0, 31);
    push(K_DONE, 8'h00);
  endtask

  task automatic pulse_frame();
    @(negedge Clk);
    bus.Frame_Req = 1'b1;
    @(negedge Clk);
    bus.Frame_Req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    repeat (5) @(negedge Clk);
    check_eq(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.Chr_Ack && n < 2000);
    check_eq(nm, bus.Chr_Ack, 1);
    bus.Chr_Req = 1'b0;
  endtask

  task automatic wait_dat(input string nm, input int target);
    int n = 0;
    while (dat_cnt < target && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check_eq(nm, dat_cnt >= target, 1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.Pos, bus.Data, bus.Set_Cursor, bus.Set_Data, bus.Clr_Screen, bus.Chr_Ack,
                bus.Frame_Busy, bus.Frame_Done, bus.Timeout_Err});
  endfunction

  // Monitor and controller model.
  initial begin
    bus.Cmd_Done = 1'b0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Rst) begin
        cd = 0;
        bus.Cmd_Done = 1'b0;
      end else begin
        bus.Cmd_Done = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) bus.Cmd_Done = 1'b1;
        end
        if (bus.Clr_Screen) begin
          got({K_CLR, 8'h00});
          cd = 3;
        end
        if (bus.Set_Cursor) begin
          got({K_CUR, bus.Pos});
          cd = 3;
        end
        if (bus.Set_Data) begin
          dat_cnt++;
          dat_cyc = cyc;
          got({K_DAT, bus.Data});
          if (dat_cnt != hold_at) cd = 3;
        end
        if (bus.Frame_Done) got({K_DONE, 8'h00});
        if (bus.Chr_Ack) got({K_ACK, 8'h00});
        if (bus.Timeout_Err) begin
          tmo_cyc = cyc;
          got({K_TMO, 8'h00});
        end
        busy_seen |= bus.Frame_Busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;
    bus.Init_Done  = 1'b0;
    bus.Frame_Req  = 1'b0;
    bus.Frame_Data = "HELLO WORLD     0123456789ABCDEF";
    bus.Chr_Req    = 1'b0;
    bus.Chr_Pos    = '0;
    bus.Chr_Data   = '0;

    repeat (3) @(negedge Clk);
    check_eq("reset_outs", outs(), 0);
    Rst = 1'b0;
    bus.Init_Done = 1'b1;
    repeat (3) @(negedge Clk);
    check_eq("idle_outs", outs(), 0);

    // Full frame
    push_frame();
    pulse_frame();
    drain("frame1");
    check_eq("frame1_busy", bus.Frame_Busy, 0);

    // Idle single char
    busy_seen = 1'b0;
    push(K_ACK, 8'h00);
    push(K_CUR, 8'd7);
    push(K_DAT, "5");
    bus.Chr_Pos  = 5'd7;
    bus.Chr_Data = "5";
    bus.Chr_Req  = 1'b1;
    wait_ack("idle_ack", n);
    check_eq("idle_ack_latency", n, 1);
    drain("idle_chr");
    check_eq("idle_chr_busy", busy_seen, 0);

    // Char interleaved after char 4
    push(K_CLR, 8'h00);
    push_chars(0, 4);
    push(K_ACK, 8'h00);
    push(K_CUR, 8'd7);
    push(K_DAT, "5");
    push(K_CUR, 8'd5);
    push_chars(5, 31);
    push(K_DONE, 8'h00);
    snap = dat_cnt;
    pulse_frame();
    wait_dat("ilv_char4", snap + 5);
    bus.Chr_Req = 1'b1;
    wait_ack("ilv_ack", n);
    drain("interleave");

    // Two extra requests during a frame merge into one more frame
    push_frame();
    push_frame();
    pulse_frame();
    repeat (20) @(negedge Clk);
    pulse_frame();
    repeat (20) @(negedge Clk);
    pulse_frame();
    drain("two_frames");

    // Watchdog abort on the third data write
    hold_at = dat_cnt + 3;
    push(K_CLR, 8'h00);
    push_chars(0, 2);
    push(K_TMO, 8'h00);
    pulse_frame();
    drain("timeout");
    check_eq("timeout_latency", tmo_cyc - dat_cyc, TMO);
    check_eq("timeout_busy", bus.Frame_Busy, 0);
    hold_at = -1;
    push_frame();
    pulse_frame();
    drain("after_timeout");

    // Requests held off by Init_Done=0, then char first, then frame
    bus.Init_Done = 1'b0;
    bus.Chr_Pos   = 5'd20;
    bus.Chr_Data  = "X";
    bus.Chr_Req   = 1'b1;
    pulse_frame();
    snap = ev_cnt;
    repeat (20) @(negedge Clk);
    check_eq("no_init_events", ev_cnt - snap, 0);
    push(K_ACK, 8'h00);
    push(K_CUR, 8'd20);
    push(K_DAT, "X");
    push_frame();
    bus.Init_Done = 1'b1;
    wait_ack("init_ack", n);
    drain("init_release");

    // Reset in the middle of a frame
    push_frame();
    snap = dat_cnt;
    pulse_frame();
    wait_dat("rst_progress", snap + 2);
    #1 Rst = 1'b1;
    #1 check_eq("midrst_outs", outs(), 0);
    exp_q.delete();
    snap = ev_cnt;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    check_eq("post_rst_events", ev_cnt - snap, 0);
    check_eq("post_rst_busy", bus.Frame_Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd1602_disp_sched.md
Name: lcd1602_disp_sched

Overview:
- Command scheduler sitting between display producers and the lcd1602_ctrl command interface (Pos/Set_Cursor, Data/Set_Data, Clr_Screen, init_done, dly_done).
- Serves two requesters:
  - a bulk frame refresh, 32 chars covering both rows;
  - single-character writes, e.g. from keypad entry.
- Issues one command at a time and waits for controller completion before the next.
- Interleaves character writes into a running frame without losing cursor continuity.

Parameters:
- NCHAR, 32, characters per frame (2 rows x 16); Pos 0-15 is row 0, 16-31 is row 1.
- ROW_LEN, 16, characters per row; a cursor command is forced at each row start.
- TMO_W, 20, width of the command-completion watchdog counter.
- TMO_MAX, 1000000, cycles to wait for Cmd_Done before aborting.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous, active-high reset
- Init_Done  in  1  controller initialisation finished
- Cmd_Done  in  1  1-cycle pulse: last command completed (controller dly_done)
- Frame_Req  in  1  1-cycle pulse: refresh the whole display
- Frame_Data  in  8*NCHAR  frame chars; char i = Frame_Data[8*NCHAR-1-8i -: 8]
- Chr_Req  in  1  level: single-char write request
- Chr_Pos  in  5  target position 0..31
- Chr_Data  in  8  ASCII code
- Chr_Ack  out  1  1-cycle pulse when the Chr request is accepted (inputs sampled)
- Frame_Busy  out  1  a frame is in progress
- Frame_Done  out  1  1-cycle pulse after char NCHAR-1 completes
- Timeout_Err  out  1  1-cycle pulse on a watchdog abort
- Pos  out  8  cursor position to the controller
- Set_Cursor  out  1  1-cycle command strobe
- Data  out  8  character to the controller
- Set_Data  out  1  1-cycle command strobe
- Clr_Screen  out  1  1-cycle command strobe (asserted at frame start)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; idx=0; frame_pend=0; need_cur=1.
- Strobe rules:
  - Exactly one of Set_Cursor, Set_Data or Clr_Screen is high for exactly one cycle per command.
  - Pos and Data are valid in the strobe cycle and held until the next command.
- FSM states: IDLE, F_CLR, F_CUR, F_DAT, C_CUR, C_DAT, WAIT.
  - WAIT records its return state and exits on Cmd_Done.
  - A Cmd_Done pulse outside WAIT is ignored.
- IDLE:
  - If Init_Done=0, stay in IDLE; no Chr_Ack is issued and Frame_Req is latched only into frame_pend.
  - Chr_Req has priority: pulse Chr_Ack and capture Chr_Pos/Chr_Data, then go to C_CUR.
  - Otherwise, if Frame_Req or frame_pend is set: snapshot Frame_Data, idx=0, Frame_Busy=1, clear frame_pend, go to F_CLR.
- Frame sequence:
  - F_CLR -> WAIT -> F_CUR (Pos=idx) -> WAIT -> F_DAT (Data=char idx) -> WAIT -> idx++.
  - F_CUR is issued only when need_cur=1 or idx mod ROW_LEN=0; otherwise go straight to F_DAT. need_cur clears after F_CUR.
  - The controller auto-increments its cursor after each data write.
- Char boundary, after each frame F_DAT completes:
  - If idx = NCHAR: pulse Frame_Done, drop Frame_Busy, go to IDLE.
  - Else, if Chr_Req=1 and the previous boundary did not serve a char: ack it, set need_cur=1, go to C_CUR. This alternation guarantees frame progress.
- C_CUR (Pos=captured pos) -> WAIT -> C_DAT -> WAIT -> return to the frame (F_CUR) if Frame_Busy, else IDLE.
- Frame_Req while Frame_Busy sets frame_pend (one deep; further requests merge). The new frame starts from IDLE after Frame_Done.
- Watchdog:
  - Counts in WAIT and resets on entry.
  - On count = TMO_MAX-1: pulse Timeout_Err, abort to IDLE, clear Frame_Busy, no Frame_Done, need_cur=1. frame_pend is retained.
- Init_Done falling in any non-IDLE state has the same abort path but no Timeout_Err.
- Rst asserted mid-operation returns everything to reset values immediately. No strobe is emitted in the following cycle.

Decomposition:
- Shared package (lcd_pkg):
  - FSM state enum;
  - NCHAR and ROW_LEN constants;
  - the char-extract function (index -> byte slice).
- A single sub-module, lcd_cmd_wdog, is natural: watchdog counter with start/clear/expire.

Test Plan:
- Frame_Req with Frame_Data="HELLO WORLD     0123456789ABCDEF" and Cmd_Done returned 3 cycles after each strobe:
  - expect Clr, then Cursor Pos=0, 16 Set_Data "H".."  ", Cursor Pos=16, 16 Set_Data "0".."F";
  - then one Frame_Done; 35 strobes total.
- Idle, Chr_Req Pos=7 Data="5":
  - Chr_Ack in the cycle after the request;
  - then Set_Cursor Pos=7 and Set_Data "5";
  - Frame_Busy stays 0.
- Chr_Req held during a frame after char idx=4: sequence must be
  - Set_Data(char4), Cursor 7, Data "5", Cursor Pos=5, Data(char5);
  - a second Chr_Req is served only after char5.
- Frame_Req pulsed twice during a running frame: exactly one extra frame runs; 2 Frame_Done total.
- Cmd_Done withheld after a Set_Data:
  - Timeout_Err pulses at TMO_MAX cycles (bench parameter 50);
  - no Frame_Done; returns to IDLE; next Frame_Req restarts with Clr_Screen.
- Init_Done=0 with Chr_Req and Frame_Req:
  - no strobes, no Chr_Ack;
  - when Init_Done rises, the char is served first, then the pending frame.
